// File: rtl/bm_mem_pkg.sv
// Shared constants and FSM encoding for the ring sequencer that wraps the
// 4-slot benchmark memory.
package bm_mem_pkg;
    localparam int BITS_DEF   = 2;
    localparam int ADDR_W_DEF = 2;
    localparam int DEPTH      = 4;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'b00,
        S_PARTIAL = 2'b01,
        S_FULL    = 2'b10
    } state_t;
endpackage

// File: rtl/bm_mod_counter.sv
// Wrapping W-bit counter with synchronous active-low reset, clear and enable.
// Used for the ring write and read pointers.
module bm_mod_counter #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (en) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/bm_mem_ring_sequencer.sv
// Address/control stage that turns a 4-slot asynchronous-read memory into a
// 4-deep FIFO with valid/ready streams on both sides.
module bm_mem_ring_sequencer
    import bm_mem_pkg::*;
#(
    parameter int BITS   = BITS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BITS-1:0]   in_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [BITS-1:0]   mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [BITS-1:0]   mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BITS-1:0]   out_data,
    input  logic              flush,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              push, pop;

    // Ready/valid come only from registered state, never from the partner's strobe.
    assign full      = (state_q == S_FULL);
    assign empty     = (state_q == S_EMPTY);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign mem_we    = push;
    assign mem_waddr = wr_ptr;
    assign mem_wdata = in_data;
    assign mem_raddr = rd_ptr;
    assign out_data  = mem_rdata;
    assign count     = count_q;

    bm_mod_counter #(.W(ADDR_W)) u_wr_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (flush),
        .en      (push),
        .q       (wr_ptr)
    );

    bm_mod_counter #(.W(ADDR_W)) u_rd_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (flush),
        .en      (pop),
        .q       (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        state_d = state_q;
        if (flush) begin
            count_d = '0;
            state_d = S_EMPTY;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
            case (state_q)
                S_EMPTY:   if (push) state_d = S_PARTIAL;
                S_PARTIAL: begin
                    if (push && !pop && count_q == LAST) begin
                        state_d = S_FULL;
                    end else if (pop && !push && count_q == ONE) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL:    if (pop) state_d = S_PARTIAL;
                default:   state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_EMPTY;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_bm_mem_ring_sequencer.sv
// Directed bench: sequencer plus a behavioural 4x2 async-read memory, with a
// reference model of occupancy/pointers and a queue scoreboard for data order.
module tb_bm_mem_ring_sequencer;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic       mem_we;
    logic [1:0] mem_waddr;
    logic [1:0] mem_wdata;
    logic [1:0] mem_raddr;
    logic [1:0] mem_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_data;
    logic       flush;
    logic [2:0] count;
    logic       full;
    logic       empty;

    logic [1:0] mem [4];

    int         tests = 0;
    int         fails = 0;
    int         exp_count;
    logic [1:0] exp_wr;
    logic [1:0] exp_rd;
    logic [1:0] sb_q[$];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_raddr];

    bm_mem_ring_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model.
    task automatic cycle(input logic v, input logic [1:0] d, input logic r,
                         input logic f, input logic rst_n);
        logic       e_push, e_pop;
        logic [1:0] e_word;
        reset_n   = rst_n;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
        e_push = v && (exp_count != 4);
        e_pop  = r && (exp_count != 0);
        chk("in_ready",  int'(in_ready),  int'(exp_count != 4));
        chk("out_valid", int'(out_valid), int'(exp_count != 0));
        chk("count",     int'(count),     exp_count);
        chk("full",      int'(full),      int'(exp_count == 4));
        chk("empty",     int'(empty),     int'(exp_count == 0));
        chk("mem_we",    int'(mem_we),    int'(e_push));
        chk("mem_waddr", int'(mem_waddr), int'(exp_wr));
        chk("mem_raddr", int'(mem_raddr), int'(exp_rd));
        if (e_push) chk("mem_wdata", int'(mem_wdata), int'(d));
        if (e_pop && rst_n) begin
            e_word = sb_q.pop_front();
            chk("out_data", int'(out_data), int'(e_word));
        end
        $display("[TB] t=%0t rst_n=%0b fl=%0b v=%0b d=%0d r=%0b push=%0b pop=%0b out=%0d cnt=%0d",
                 $time, rst_n, f, v, d, r, e_push, e_pop, out_data, count);
        if (!rst_n || f) begin
            sb_q.delete();
            exp_count = 0;
            exp_wr    = 2'd0;
            exp_rd    = 2'd0;
        end else begin
            if (e_push) begin
                sb_q.push_back(d);
                exp_wr = exp_wr + 2'd1;
            end
            if (e_pop) exp_rd = exp_rd + 2'd1;
            exp_count = exp_count + int'(e_push) - int'(e_pop);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 2'd0;
        out_ready = 1'b0;
        flush     = 1'b0;
        exp_count = 0;
        exp_wr    = 2'd0;
        exp_rd    = 2'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);

        // Reset state and idle
        cycle(0, 2'd0, 0, 0, 1);
        cycle(0, 2'd0, 0, 0, 1);

        // Fill to full, then a fifth word must be refused
        cycle(1, 2'd1, 0, 0, 1);
        cycle(1, 2'd2, 0, 0, 1);
        cycle(1, 2'd3, 0, 0, 1);
        cycle(1, 2'd0, 0, 0, 1);
        cycle(1, 2'd2, 0, 0, 1);

        // Drain in order
        for (int i = 0; i < 4; i++) cycle(0, 2'd0, 1, 0, 1);
        cycle(0, 2'd0, 1, 0, 1);

        // Prefill 2, then steady stream across pointer wrap
        cycle(1, 2'd1, 0, 0, 1);
        cycle(1, 2'd3, 0, 0, 1);
        for (int i = 0; i < 10; i++) cycle(1, 2'(i * 3 + 2), 1, 0, 1);

        // Reach 3 words, flush with a concurrent push, then reuse from address 0
        cycle(1, 2'd1, 0, 0, 1);
        cycle(1, 2'd3, 1, 1, 1);
        cycle(0, 2'd0, 0, 0, 1);
        cycle(1, 2'd2, 0, 0, 1);
        cycle(0, 2'd0, 1, 0, 1);
        cycle(0, 2'd0, 0, 0, 1);

        // Two words stored, reset while both strobes are high
        cycle(1, 2'd3, 0, 0, 1);
        cycle(1, 2'd1, 0, 0, 1);
        cycle(1, 2'd2, 1, 0, 0);
        cycle(0, 2'd0, 0, 0, 1);
        cycle(1, 2'd3, 0, 0, 1);
        cycle(0, 2'd0, 1, 0, 1);
        cycle(0, 2'd0, 0, 0, 1);

        chk("sb_left", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
